// File: rtl/pe_result_drain_pkg.sv
// pe_types: shared state encoding and result helpers for the PE result drain.
package pe_types;

   typedef enum logic {DRAIN_IDLE, DRAIN_STREAM} pe_drain_state_t;

   // Positive saturation pattern {0,1...1} for a signed result of the given width (<= 64).
   function automatic logic [63:0] pe_result_sat_max(input int unsigned width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/pe_result_drain_bank_fifo.sv
// pe_result_bank_fifo: bank-wide FIFO holding captured PE result banks.
// Exposes the head bank and the bank behind it so the drain can preload its
// registered output across a pop without a bubble. The caller must never write
// when full without also popping, and never pop when empty.
module pe_result_bank_fifo #(
   parameter int unsigned Width = 128,
   parameter int unsigned Depth = 4
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     wr_en,
   input  logic [Width-1:0]         wr_data,
   input  logic                     pop,
   output logic [Width-1:0]         head,
   output logic [Width-1:0]         next_head,
   output logic [$clog2(Depth):0]   level,
   output logic                     full
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned LevelW = PtrW + 1;

   logic [Width-1:0]  mem [Depth];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [LevelW-1:0] level_q;

   assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
   assign head       = mem[rd_ptr_q];
   assign next_head  = mem[rd_ptr_nxt];
   assign level      = level_q;
   assign full       = (level_q == LevelW'(Depth));

   // Bank storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   // Pointers wrap naturally since Depth is a power of two.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_nxt;
         end
         if (wr_en && !pop) begin
            level_q <= level_q + LevelW'(1);
         end else if (!wr_en && pop) begin
            level_q <= level_q - LevelW'(1);
         end
      end
   end

endmodule

// File: rtl/pe_result_drain.sv
// pe_result_drain: captures a full PE row of results after each accumulator
// flush and streams them out one lane per handshake.
// Optional feature macro: PE_DRAIN_SAT_COUNT_EN adds o_sat_count, a saturating
// count of streamed lanes that hold +max or -max.
module pe_result_drain
   import pe_types::*;
#(
   parameter int unsigned NUM_PES       = 4,
   parameter int unsigned RESULT_WIDTH  = 32,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned FLUSH_LATENCY = 1
) (
   input  logic                              clock,
   input  logic                              resetn,
   input  logic                              i_flush_accumulator,
   input  logic [NUM_PES*RESULT_WIDTH-1:0]   i_results,
   input  logic                              i_clear_overflow,
   output logic signed [RESULT_WIDTH-1:0]    o_data,
   output logic [$clog2(NUM_PES)-1:0]        o_lane,
   output logic                              o_last,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [$clog2(FIFO_DEPTH):0]       o_level,
   output logic                              o_overflow
`ifdef PE_DRAIN_SAT_COUNT_EN
   ,
   output logic [15:0]                       o_sat_count
`endif
);

   localparam int unsigned LaneW  = $clog2(NUM_PES);
   localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BankW  = NUM_PES * RESULT_WIDTH;
   localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_PES - 1);

   logic [FLUSH_LATENCY-1:0] dly_q, dly_d;
   logic                     cap_strobe, accept, fire, pop, busy;
   logic [BankW-1:0]         head, next_head, src_bank;
   logic [LevelW-1:0]        level;
   logic                     full;
   pe_drain_state_t          state_q, state_d;
   logic [LaneW-1:0]         cnt_q, cnt_d;
   logic                     last_q, last_d;
   logic [RESULT_WIDTH-1:0]  data_q, data_d;
   logic                     ovf_q, ovf_d;

   if (FLUSH_LATENCY > 1) begin : g_dly_multi
      assign dly_d = {dly_q[FLUSH_LATENCY-2:0], i_flush_accumulator};
   end else begin : g_dly_single
      assign dly_d = i_flush_accumulator;
   end

   assign cap_strobe = dly_q[FLUSH_LATENCY-1];
   assign fire       = (state_q == DRAIN_STREAM) && i_ready;
   assign pop        = fire && last_q;
   // A full FIFO still takes a capture if its head bank leaves on the same edge.
   assign accept     = cap_strobe && (!full || pop);
   assign busy       = accept || (level > LevelW'(pop));
   // Bank that will be at the head after this edge; the incoming bank when the
   // FIFO is (or becomes) empty, since it lands in the head slot.
   assign src_bank   = pop ? ((level == LevelW'(1)) ? i_results : next_head)
                           : ((level == '0) ? i_results : head);

   pe_result_bank_fifo #(
      .Width (BankW),
      .Depth (FIFO_DEPTH)
   ) u_bank_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .wr_en     (accept),
      .wr_data   (i_results),
      .pop       (pop),
      .head      (head),
      .next_head (next_head),
      .level     (level),
      .full      (full)
   );

   // Next stream state, lane counter and preloaded output lane.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (fire) begin
         cnt_d = last_q ? '0 : cnt_q + LaneW'(1);
      end
      unique case (state_q)
         DRAIN_IDLE:   if (accept) state_d = DRAIN_STREAM;
         DRAIN_STREAM: if (!busy) state_d = DRAIN_IDLE;
         default:      state_d = DRAIN_IDLE;
      endcase
      last_d = (state_d == DRAIN_STREAM) && (cnt_d == LastLane);
      data_d = (state_d == DRAIN_STREAM) ? src_bank[cnt_d*RESULT_WIDTH +: RESULT_WIDTH] : data_q;
   end

   // Stream state and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= DRAIN_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   // Overflow is sticky; a drop in the same cycle as a clear wins.
   assign ovf_d = (cap_strobe && !accept) ? 1'b1 : (i_clear_overflow ? 1'b0 : ovf_q);

   // Flush delay line and overflow flag.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dly_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         dly_q <= dly_d;
         ovf_q <= ovf_d;
      end
   end

   assign o_valid    = (state_q == DRAIN_STREAM);
   assign o_data     = data_q;
   assign o_lane     = cnt_q;
   assign o_last     = last_q;
   assign o_level    = level;
   assign o_overflow = ovf_q;

`ifdef PE_DRAIN_SAT_COUNT_EN
   localparam logic [RESULT_WIDTH-1:0] SatPos = RESULT_WIDTH'(pe_result_sat_max(RESULT_WIDTH));

   logic [15:0] sat_cnt_q;
   logic        sat_hit;

   assign sat_hit = fire && ((data_q == SatPos) || (data_q == ~SatPos));

   // Count handed-over lanes at either saturation rail; sticks at all-ones.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sat_cnt_q <= '0;
      end else if (i_clear_overflow) begin
         sat_cnt_q <= '0;
      end else if (sat_hit && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

   assign o_sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: expected lanes are queued when a flush is issued
// and compared in order as the DUT hands lanes over.
`timescale 1ns/1ps
module tb_pe_result_drain;

   localparam int unsigned NP = 4;
   localparam int unsigned RW = 32;
   localparam int unsigned FD = 4;

   typedef struct packed {
      logic [RW-1:0] data;
      logic [1:0]    lane;
      logic          last;
   } exp_t;

   logic             clock   = 1'b0;
   logic             resetn  = 1'b0;
   logic             flush   = 1'b0;
   logic [NP*RW-1:0] results = '0;
   logic             clr     = 1'b0;
   logic             ready   = 1'b0;
   logic [RW-1:0]    data;
   logic [1:0]       lane;
   logic             last;
   logic             valid;
   logic [2:0]       level;
   logic             overflow;
`ifdef PE_DRAIN_SAT_COUNT_EN
   logic [15:0]      sat_count;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   pe_result_drain #(
      .NUM_PES       (NP),
      .RESULT_WIDTH  (RW),
      .FIFO_DEPTH    (FD),
      .FLUSH_LATENCY (1)
   ) dut (
      .clock               (clock),
      .resetn              (resetn),
      .i_flush_accumulator (flush),
      .i_results           (results),
      .i_clear_overflow    (clr),
      .o_data              (data),
      .o_lane              (lane),
      .o_last              (last),
      .o_valid             (valid),
      .i_ready             (ready),
      .o_level             (level),
      .o_overflow          (overflow)
`ifdef PE_DRAIN_SAT_COUNT_EN
      ,
      .o_sat_count         (sat_count)
`endif
   );

   function automatic logic [NP*RW-1:0] mk_bank(input logic [RW-1:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic push_bank(input logic [NP*RW-1:0] bank);
      for (int i = 0; i < NP; i++) begin
         exp_q.push_back('{data: bank[i*RW +: RW], lane: 2'(i), last: (i == NP - 1)});
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", valid);
      end
      checks++;
      if (level !== 3'd0) begin
         errors++; $display("FAIL reset_level: got %0d want 0", level);
      end
      checks++;
      if ({data, lane, last, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got data %h lane %0d last %b ovf %b want all 0",
                  data, lane, last, overflow);
      end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_single_flush();
      logic [NP*RW-1:0] bank;
      exp_t got;
      bank  = mk_bank(32'd10, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         flush   = (c == 0);
         results = (c == 1) ? bank : '0;
         if (c == 1) push_bank(bank);
         checks++;
         if (valid !== ((c >= 2) && (c <= 5))) begin
            errors++; $display("FAIL single_valid: cycle %0d got %b", c, valid);
         end
         if (c == 2 || c == 5 || c == 6) begin
            checks++;
            if (level !== ((c == 6) ? 3'd0 : 3'd1)) begin
               errors++; $display("FAIL single_level: cycle %0d got %0d", c, level);
            end
         end
         if (valid === 1'b1) begin
            checks++;
            got = '{data: data, lane: lane, last: last};
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL single_extra: got data %h lane %0d, none expected", data, lane);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL single_lane: got %h/%0d/%b want %h/%0d/%b", data, lane, last,
                           exp_q[0].data, exp_q[0].lane, exp_q[0].last);
               end
               if (ready) void'(exp_q.pop_front());
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL single_missing: %0d lanes not streamed, want 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [NP*RW-1:0] bank;
      logic [15:0]      rpat;
      exp_t got;
      bank = mk_bank(32'd1, 32'd2, 32'd3, 32'd4);
      rpat = 16'b1111_1111_1101_1001;  // from bit 0: 1,0,0,1,1,0,1,1,...
      for (int c = 0; c < 14; c++) begin
         flush   = (c == 0);
         results = (c == 1) ? bank : '0;
         if (c == 1) push_bank(bank);
         ready = (c < 2) ? 1'b1 : rpat[c-2];
         if (valid === 1'b1) begin
            checks++;
            got = '{data: data, lane: lane, last: last};
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL bp_extra: got data %h lane %0d, none expected", data, lane);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL bp_lane: got %h/%0d/%b want %h/%0d/%b", data, lane, last,
                           exp_q[0].data, exp_q[0].lane, exp_q[0].last);
               end
               if (ready) void'(exp_q.pop_front());
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0 || valid !== 1'b0) begin
         errors++; $display("FAIL bp_done: left %0d valid %b, want 0 and 0", exp_q.size(), valid);
      end
   endtask

   task automatic test_overflow();
      logic [NP*RW-1:0] banks [5];
      exp_t got;
      for (int k = 0; k < 5; k++) begin
         banks[k] = mk_bank(32'(100 + 16*k), 32'(101 + 16*k), 32'(102 + 16*k), 32'(103 + 16*k));
      end
      ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         flush   = (c < 5);
         results = (c >= 1 && c <= 5) ? banks[c-1] : '0;
         if (c >= 1 && c <= 4) push_bank(banks[c-1]);
         step();
      end
      checks++;
      if (level !== 3'd4 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_full: got level %0d ovf %b want 4 1", level, overflow);
      end
      for (int c = 0; c < 24; c++) begin
         ready = (c >= 2);
         if (valid === 1'b1) begin
            checks++;
            got = '{data: data, lane: lane, last: last};
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL ovf_extra: got data %h lane %0d, none expected", data, lane);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL ovf_lane: got %h/%0d/%b want %h/%0d/%b", data, lane, last,
                           exp_q[0].data, exp_q[0].lane, exp_q[0].last);
               end
               if (ready) void'(exp_q.pop_front());
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0 || level !== 3'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drained: left %0d level %0d ovf %b want 0 0 1", exp_q.size(), level, overflow);
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
      end
   endtask

   task automatic test_full_pop();
      logic [NP*RW-1:0] banks [4];
      logic [NP*RW-1:0] bank_e;
      exp_t got;
      for (int k = 0; k < 4; k++) begin
         banks[k] = mk_bank(32'(500 + 8*k), 32'(501 + 8*k), 32'(502 + 8*k), 32'(503 + 8*k));
      end
      bank_e = mk_bank(32'hE0, 32'hE1, 32'hE2, 32'hE3);
      ready  = 1'b0;
      for (int c = 0; c < 6; c++) begin
         flush   = (c < 4);
         results = (c >= 1 && c <= 4) ? banks[c-1] : '0;
         if (c >= 1 && c <= 4) push_bank(banks[c-1]);
         step();
      end
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         errors++; $display("FAIL fullpop_fill: got level %0d ovf %b want 4 0", level, overflow);
      end
      ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         flush   = (c == 2);
         results = (c == 3) ? bank_e : '0;
         if (c == 3) push_bank(bank_e);
         if (c == 4) begin
            checks++;
            if (level !== 3'd4 || overflow !== 1'b0) begin
               errors++; $display("FAIL fullpop_same_edge: got level %0d ovf %b want 4 0", level, overflow);
            end
         end
         if (valid === 1'b1) begin
            checks++;
            got = '{data: data, lane: lane, last: last};
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL fullpop_extra: got data %h lane %0d, none expected", data, lane);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL fullpop_lane: got %h/%0d/%b want %h/%0d/%b", data, lane, last,
                           exp_q[0].data, exp_q[0].lane, exp_q[0].last);
               end
               if (ready) void'(exp_q.pop_front());
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0 || level !== 3'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fullpop_done: left %0d level %0d ovf %b want 0 0 0", exp_q.size(), level, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [NP*RW-1:0] banks [3];
      exp_t got;
      for (int k = 0; k < 3; k++) begin
         banks[k] = mk_bank(32'(900 + 4*k), 32'(901 + 4*k), 32'(902 + 4*k), 32'(903 + 4*k));
      end
      ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         flush   = (c < 3);
         results = (c >= 1 && c <= 3) ? banks[c-1] : '0;
         if (c >= 1 && c <= 3) push_bank(banks[c-1]);
         if (c >= 2 && c <= 14) begin
            checks++;
            if (valid !== (c <= 13)) begin
               errors++; $display("FAIL b2b_valid: cycle %0d got %b want %b", c, valid, (c <= 13));
            end
         end
         if (valid === 1'b1) begin
            checks++;
            got = '{data: data, lane: lane, last: last};
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra: got data %h lane %0d, none expected", data, lane);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL b2b_lane: got %h/%0d/%b want %h/%0d/%b", data, lane, last,
                           exp_q[0].data, exp_q[0].lane, exp_q[0].last);
               end
               if (ready) void'(exp_q.pop_front());
            end
         end
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_missing: %0d lanes not streamed, want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [NP*RW-1:0] bank;
      bank  = mk_bank(32'h11, 32'h22, 32'h33, 32'h44);
      ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         flush   = (c == 0);
         results = (c == 1) ? bank : '0;
         step();
      end
      checks++;
      if (valid !== 1'b1 || lane !== 2'd2 || data !== 32'h33) begin
         errors++; $display("FAIL rstmid_lane2: got valid %b lane %0d data %h want 1 2 33", valid, lane, data);
      end
      ready = 1'b0;
      flush = 1'b1;
      step();
      flush  = 1'b0;
      resetn = 1'b0;
      #1;
      checks++;
      if (valid !== 1'b0 || level !== 3'd0 || lane !== 2'd0) begin
         errors++; $display("FAIL rstmid_async: got valid %b level %0d lane %0d want 0 0 0", valid, level, lane);
      end
      exp_q.delete();
      results = bank;
      #2;
      resetn = 1'b1;
      ready  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (valid !== 1'b0 || level !== 3'd0) begin
            errors++; $display("FAIL rstmid_no_capture: cycle %0d got valid %b level %0d want 0 0", c, valid, level);
         end
      end
      results = '0;
   endtask

`ifdef PE_DRAIN_SAT_COUNT_EN
   task automatic test_sat_count();
      logic [NP*RW-1:0] bank;
      bank  = mk_bank(32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h8000_0000);
      ready = 1'b1;
      clr   = 1'b1;
      step();
      clr   = 1'b0;
      checks++;
      if (sat_count !== 16'd0) begin
         errors++; $display("FAIL sat_clear: got %0d want 0", sat_count);
      end
      for (int c = 0; c < 10; c++) begin
         flush   = (c == 0);
         results = (c == 1) ? bank : '0;
         step();
      end
      checks++;
      if (sat_count !== 16'd3) begin
         errors++; $display("FAIL sat_count: got %0d want 3", sat_count);
      end
   endtask
`endif

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_flush();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_back_to_back();
`ifdef PE_DRAIN_SAT_COUNT_EN
      test_sat_count();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Drains fixed-point accumulator results from a row of PEs after each accumulator flush.
- Captures all NUM_PES results in parallel one bank at a time, buffers banks in a small FIFO, and streams them out one lane at a time over a valid/ready interface toward the output writer.
- Sits at the result end of the PE array, one instance per PE row.

Parameters:
NUM_PES, 4, number of PE result lanes captured per flush
RESULT_WIDTH, 32, signed result width per lane
FIFO_DEPTH, 4, number of result banks buffered (power of 2, >=2)
FLUSH_LATENCY, 1, cycles from i_flush_accumulator to a valid result on i_results

Ports:
clock  input  1  clock
resetn  input  1  asynchronous active-low reset
i_flush_accumulator  input  1  same flush strobe driven to the PE accumulators
i_results  input  NUM_PES*RESULT_WIDTH  packed PE results, lane 0 in LSBs
i_clear_overflow  input  1  clears sticky o_overflow
o_data  output  RESULT_WIDTH  current streamed result (signed)
o_lane  output  $clog2(NUM_PES)  lane index of o_data
o_last  output  1  high with lane NUM_PES-1
o_valid  output  1  o_data valid
i_ready  input  1  consumer accepts when o_valid && i_ready
o_level  output  $clog2(FIFO_DEPTH)+1  banks currently held (includes bank being streamed)
o_overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset (resetn low, asynchronous): flush delay line cleared, pointers 0, state IDLE. o_valid=0, o_data=0, o_lane=0, o_last=0, o_level=0, o_overflow=0. Reset mid-stream discards all buffered banks and any flush in flight.
- Capture: i_flush_accumulator is delayed FLUSH_LATENCY cycles (reset-capable delay line) to form cap_strobe.
  - On cap_strobe, all lanes of i_results are written as one bank at the write pointer.
- Full rule: a capture is accepted if level<FIFO_DEPTH, or if the final lane of the head bank pops in the same cycle.
  - Otherwise the bank is dropped, o_overflow is set, and pointers are unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- o_level = writes minus completed bank pops.
  - Updates the cycle after the event.
  - Simultaneous accept and pop leaves it unchanged.
- Stream FSM:
  - IDLE: o_valid=0. Go to STREAM when level>0 (first o_valid the cycle after the capture edge; lane counter=0).
  - STREAM: o_valid=1. o_data = head bank lane[lane counter]. o_lane = counter. o_last = (counter==NUM_PES-1).
    - On handshake with counter<NUM_PES-1: counter increments.
    - On handshake with o_last: counter=0, head bank popped. Stay in STREAM if another bank remains, else go to IDLE (no bubble between banks).
- Outputs are registered. o_data, o_lane and o_last hold stable while o_valid && !i_ready.
- Throughput: 1 lane/cycle with i_ready held high.
- o_overflow: set on a dropped capture; cleared by i_clear_overflow. Simultaneous set and clear: set wins.
- Back-to-back flushes every cycle are legal and accepted until full.

Optional Feature:
- PE_DRAIN_SAT_COUNT_EN defined: adds output o_sat_count (16 bits).
  - Increments once per streamed lane handshake whose o_data equals +max ({0,1...1}) or -max ({1,0...0}).
  - Saturates at 16'hFFFF.
  - Reset to 0; cleared by i_clear_overflow.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- pe_types gets typedef enum logic {DRAIN_IDLE, DRAIN_STREAM} pe_drain_state_t and a function pe_result_sat_max(width) returning the positive saturation pattern.
- Sub-module pe_result_bank_fifo: NUM_PES*RESULT_WIDTH wide, FIFO_DEPTH deep. Provides write/pop, full/level, and head-bank read.
- The drain module holds only the capture delay, lane counter, FSM and flags.

Test Plan:
- Single flush with lanes {10,-3,0x7FFFFFFF,-1}, i_ready=1: expect o_valid for 4 consecutive cycles with o_data 10,-3,0x7FFFFFFF,-1, o_lane 0..3, o_last only on lane 3, o_level 1->0.
- Backpressure: i_ready toggles 1,0,0,1 during a bank: o_data and o_lane are held during stalls, no lane is lost or duplicated.
- i_ready=0 and 5 flushes with FIFO_DEPTH=4: o_level=4, o_overflow=1, 5th bank absent. Then i_ready=1: 16 lanes stream in order. i_clear_overflow then drops o_overflow to 0.
- Full FIFO, with capture coinciding with the last-lane pop: capture accepted, o_level stays 4, o_overflow stays 0.
- Assert resetn low mid-bank (lane 2): o_valid drops asynchronously, o_level=0, and a flush pending in the delay line produces no capture after release.
- With PE_DRAIN_SAT_COUNT_EN: bank {0x7FFFFFFF,0x80000000,5,0x80000000} fully streamed gives o_sat_count=3.
